req_gnt_responder: RTL

//  Responder (slave end) of the req/gnt/data handshake used by our initiator-side blocks.

---
 rtl/req_gnt_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/req_gnt_responder.sv
// Responder end of the req/gnt/data handshake. Grants initiator requests, captures
// each granted word into a small FIFO and drains it over a valid/ready stream port.
// gnt is withheld while the FIFO is full, which is the only form of backpressure.

module req_gnt_responder #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned GNT_DELAY = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [DATA_W-1:0]        data,
    output logic                     gnt,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     proto_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    // WAIT counts down from GNT_DELAY-1 to 0, then grants on the following edge.
    localparam logic [3:0] DlyInit = (GNT_DELAY == 0) ? 4'd0 : 4'(GNT_DELAY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

    state_e            state_q;
    logic [3:0]        dly_q;
    logic              gnt_q;
    logic              proto_err_q;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic not_full;
    logic wr_en;
    logic rd_en;

    assign not_full  = (count_q != CntFull);
    assign wr_en     = (state_q == StGrant) && req;
    assign rd_en     = (count_q != '0) && out_ready;

    assign gnt       = gnt_q;
    assign proto_err = proto_err_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_data_q;

    // Grant FSM; gnt is registered alongside the state so it equals state==GRANT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            dly_q       <= 4'd0;
            gnt_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            gnt_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req && not_full) begin
                        if (GNT_DELAY == 0) begin
                            state_q <= StGrant;
                            gnt_q   <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            dly_q   <= DlyInit;
                        end
                    end
                end
                StWait: begin
                    if (!req) begin
                        proto_err_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (dly_q != 4'd0) begin
                        dly_q <= dly_q - 4'd1;
                    end else if (not_full) begin
                        state_q <= StGrant;
                        gnt_q   <= 1'b1;
                    end
                end
                StGrant: begin
                    // Write happens in the FIFO block; here only the dropped-req case matters.
                    if (!req) begin
                        proto_err_q <= 1'b1;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Next head pointer, occupancy and head word after this edge.
    always_comb begin
        rd_ptr_nxt = rd_en ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
        count_d    = count_q + CntW'(wr_en) - CntW'(rd_en);
        out_data_d = out_data_q;
        if (count_d != '0) begin
            // The new head may be the word being written right now (empty or single-entry FIFO).
            if (wr_en && (rd_ptr_nxt == wr_ptr_q)) begin
                out_data_d = data;
            end else begin
                out_data_d = mem_q[rd_ptr_nxt];
            end
        end
    end

    // Storage array; no reset so contents are simply discarded.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // FIFO pointers, occupancy and registered head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            rd_ptr_q   <= rd_ptr_nxt;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
